// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg: address map, status bit positions and decode helper shared by
// the dmem responder and its bench.
package dmem_map_pkg;

  localparam logic [31:0] MMIO_TX_DATA   = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_TX_STATUS = 32'hFFFF_FFF1;
  localparam logic [31:0] MMIO_CYCLE     = 32'hFFFF_FFF2;

  localparam int STAT_FULL  = 16;
  localparam int STAT_EMPTY = 17;
  localparam int STAT_OVF   = 18;

  typedef enum logic [2:0] {
    SEL_NONE      = 3'd0,
    SEL_RAM       = 3'd1,
    SEL_TX_DATA   = 3'd2,
    SEL_TX_STATUS = 3'd3,
    SEL_CYCLE     = 3'd4
  } dmem_sel_e;

  // RAM wins over the MMIO constants only if addr_w were 32, which the
  // map does not allow; anything unmatched is a dead address.
  function automatic dmem_sel_e dmem_decode(input logic [31:0] addr,
                                            input int unsigned addr_w);
    dmem_sel_e sel;
    sel = SEL_NONE;
    if ((addr >> addr_w) == 32'd0) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        MMIO_TX_DATA:   sel = SEL_TX_DATA;
        MMIO_TX_STATUS: sel = SEL_TX_STATUS;
        MMIO_CYCLE:     sel = SEL_CYCLE;
        default:        sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core dmem port plus the outgoing TX stream.
// master = core/wrapper side, slave = the responder.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_data, tx_valid
  );

  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: synchronous FIFO behind the TX_DATA register. A push into a
// full FIFO still lands when the head is popped on the same edge; otherwise
// it is dropped and flagged on o_drop. DEPTH must be a power of two (>= 2)
// so the pointers wrap on their own.
module mmio_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_accept;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_valid  = !o_empty;
  assign w_pop    = o_valid && i_ready;
  assign w_accept = i_push && (!o_full || w_pop);
  assign o_drop   = i_push && !w_accept;
  assign o_count  = r_count;
  assign o_dout   = o_empty ? '0 : r_buf[r_rptr];

  // pointer and occupancy bookkeeping; simultaneous push+pop keeps count
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // storage is not reset; when full with a pop, the write slot is the one
  // being read out this cycle, whose old value has already been presented
  always_ff @(posedge i_clock) begin
    if (w_accept) r_buf[r_wptr] <= i_din;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed RAM plus MMIO window (TX FIFO, cycle
// counter) on the core's dmem port. Reads are combinational, writes land on
// the rising edge.
// Build option TX_OVF_STICKY_EN: overflow flag holds until reset or any
// write to TX_STATUS; without it the flag shows only for the cycle after a
// dropped push and TX_STATUS writes are ignored.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clock,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_cycle;
  logic              r_ovf;

  dmem_sel_e         w_sel;
  logic [ADDR_W-1:0] w_ram_idx;
  logic              w_wr_ram;
  logic              w_wr_tx;
  logic              w_wr_cycle;
  logic [31:0]       w_status;
  logic [31:0]       w_fifo_dout;
  logic              w_fifo_valid;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_drop;

  assign w_sel      = dmem_decode(bus.address_dmem, ADDR_W);
  assign w_ram_idx  = bus.address_dmem[ADDR_W-1:0];
  assign w_wr_ram   = bus.wren && (w_sel == SEL_RAM);
  assign w_wr_tx    = bus.wren && (w_sel == SEL_TX_DATA);
  assign w_wr_cycle = bus.wren && (w_sel == SEL_CYCLE);

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32),
    .CNT_W (CNT_W)
  ) u_tx_fifo (
    .i_clock (clock),
    .i_reset (reset),
    .i_push  (w_wr_tx),
    .i_din   (bus.data),
    .i_ready (bus.tx_ready),
    .o_dout  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_drop  (w_drop)
  );

  assign bus.tx_data  = w_fifo_dout;
  assign bus.tx_valid = w_fifo_valid;

  // TX_STATUS word: occupancy in the low half, flags above it
  always_comb begin
    w_status                 = '0;
    w_status[CNT_W-1:0]      = w_fifo_count;
    w_status[STAT_FULL]      = w_fifo_full;
    w_status[STAT_EMPTY]     = w_fifo_empty;
    w_status[STAT_OVF]       = r_ovf;
  end

  // zero-latency read mux from pre-edge state
  always_comb begin
    bus.q_dmem = '0;
    case (w_sel)
      SEL_RAM:       bus.q_dmem = r_mem[w_ram_idx];
      SEL_TX_STATUS: bus.q_dmem = w_status;
      SEL_CYCLE:     bus.q_dmem = r_cycle;
      default:       bus.q_dmem = '0;
    endcase
  end

  // RAM keeps its contents across reset
  always_ff @(posedge clock) begin
    if (w_wr_ram) r_mem[w_ram_idx] <= bus.data;
  end

  // free-running cycle counter; a write to CYCLE restarts it at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_cycle <= '0;
    else if (w_wr_cycle) r_cycle <= '0;
    else                 r_cycle <= r_cycle + 32'd1;
  end

`ifdef TX_OVF_STICKY_EN
  logic w_wr_status;
  assign w_wr_status = bus.wren && (w_sel == SEL_TX_STATUS);

  // sticky overflow: set by a dropped push, cleared by any TX_STATUS write
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            r_ovf <= 1'b0;
    else if (w_drop)      r_ovf <= 1'b1;
    else if (w_wr_status) r_ovf <= 1'b0;
  end
`else
  // one-cycle overflow pulse following a dropped push
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_ovf <= 1'b0;
    else       r_ovf <= w_drop;
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test-plan steps followed by a randomized
// phase, all compared against a queue/array model of the memory map.
module tb_dmem_responder;
  import dmem_map_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFF8;

  logic clock = 1'b0;
  logic reset;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W     (12),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] fifo_m [$];
  logic [31:0] cyc_m;
  logic        ovf_m;
  logic [31:0] mem_m [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_status();
    return {13'd0, ovf_m, fifo_m.size() == 0, fifo_m.size() == DEPTH, 16'(fifo_m.size())};
  endfunction

  function automatic bit m_known(input logic [31:0] a);
    return (a >= 32'h1000) || mem_m.exists(int'(a));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'h1000)          return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0;
    if (a == MMIO_TX_STATUS)   return m_status();
    if (a == MMIO_CYCLE)       return cyc_m;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_head();
    return (fifo_m.size() != 0) ? fifo_m[0] : 32'h0;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
  endtask

  task automatic m_reset();
    fifo_m.delete();
    cyc_m = 32'd0;
    ovf_m = 1'b0;
  endtask

  // advance the model by the edge about to happen, then cross the edge
  task automatic tick();
    bit pop, push, drop;
    logic [31:0] a;
    a    = bus.address_dmem;
    pop  = (fifo_m.size() != 0) && bus.tx_ready;
    push = bus.wren && (a == MMIO_TX_DATA);
    drop = push && (fifo_m.size() == DEPTH) && !pop;
    if (pop) void'(fifo_m.pop_front());
    if (push && !drop) fifo_m.push_back(bus.data);
`ifdef TX_OVF_STICKY_EN
    if (drop) ovf_m = 1'b1;
    else if (bus.wren && a == MMIO_TX_STATUS) ovf_m = 1'b0;
`else
    ovf_m = drop;
`endif
    cyc_m = (bus.wren && a == MMIO_CYCLE) ? 32'd0 : cyc_m + 32'd1;
    if (bus.wren && a < 32'h1000) mem_m[int'(a)] = bus.data;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag);
    if (m_known(bus.address_dmem)) chk({tag, ".q"}, bus.q_dmem, m_read(bus.address_dmem));
    chk({tag, ".valid"}, {31'd0, bus.tx_valid}, {31'd0, fifo_m.size() != 0});
    chk({tag, ".txd"}, bus.tx_data, m_head());
  endtask

  initial begin
    logic [31:0] a;
    int op;

    // reset state
    reset = 1'b1;
    bus.tx_ready = 1'b0;
    drive(MMIO_TX_STATUS, 32'h0, 1'b0);
    m_reset();
    #3;
    chk("rst_status", bus.q_dmem, 32'h0002_0000);
    chk("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_txdata", bus.tx_data, 32'd0);
    drive(MMIO_CYCLE, 32'h0, 1'b0);
    #1;
    chk("rst_cycle", bus.q_dmem, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // RAM write/read, out-of-range read
    drive(32'd5, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive(32'd5, 32'h0, 1'b0);
    #2;
    chk("ram5", bus.q_dmem, 32'hDEAD_BEEF);
    drive(32'h0000_1000, 32'h0, 1'b0);
    #2;
    chk("ram_oob", bus.q_dmem, 32'h0);
    tick();

    // fill FIFO with ready low, then overflow
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(MMIO_TX_DATA, 32'(i), 1'b1);
      tick();
    end
    drive(MMIO_TX_STATUS, 32'h0, 1'b0);
    #2;
    chk("full_status", bus.q_dmem, 32'h0001_0008);
    chk("full_model", bus.q_dmem, m_status());
    drive(MMIO_TX_DATA, 32'd9, 1'b1);
    tick();
    drive(MMIO_TX_STATUS, 32'h0, 1'b0);
    #2;
    chk("ovf_status", bus.q_dmem, 32'h0005_0008);
    for (int i = 0; i < 3; i++) tick();
    #1;
`ifdef TX_OVF_STICKY_EN
    chk("ovf_sticky", bus.q_dmem, 32'h0005_0008);
`else
    chk("ovf_pulse", bus.q_dmem, 32'h0001_0008);
`endif
    drive(MMIO_TX_STATUS, 32'h1234_5678, 1'b1);
    tick();
    drive(MMIO_TX_STATUS, 32'h0, 1'b0);
    #2;
    chk("ovf_cleared", bus.q_dmem, 32'h0001_0008);

    // drain 1..8
    bus.tx_ready = 1'b1;
    drive(IDLE_ADDR, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("drain_v%0d", i), {31'd0, bus.tx_valid}, 32'd1);
      chk($sformatf("drain_d%0d", i), bus.tx_data, 32'(i + 1));
      tick();
    end
    drive(MMIO_TX_STATUS, 32'h0, 1'b0);
    #2;
    chk("drained_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("drained_status", bus.q_dmem, 32'h0002_0000);

    // full + pop + push in the same cycle
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(MMIO_TX_DATA, 32'(100 + i), 1'b1);
      tick();
    end
    bus.tx_ready = 1'b1;
    drive(MMIO_TX_DATA, 32'h0000_00A5, 1'b1);
    tick();
    drive(MMIO_TX_STATUS, 32'h0, 1'b0);
    #2;
    chk("popush_status", bus.q_dmem, 32'h0001_0008);
    drive(IDLE_ADDR, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk($sformatf("popush_d%0d", i), bus.tx_data, (i == 7) ? 32'h0000_00A5 : 32'(102 + i));
      tick();
    end
    #2;
    chk("popush_empty", {31'd0, bus.tx_valid}, 32'd0);

    // cycle counter restart
    drive(MMIO_CYCLE, 32'hFFFF_FFFF, 1'b1);
    tick();
    drive(MMIO_CYCLE, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    #2;
    chk("cycle10", bus.q_dmem, 32'd10);
    chk("cycle_model", bus.q_dmem, cyc_m);

    // reset mid-drain with 4 queued
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(MMIO_TX_DATA, 32'(200 + i), 1'b1);
      tick();
    end
    bus.tx_ready = 1'b1;
    drive(IDLE_ADDR, 32'h0, 1'b0);
    tick();
    #1;
    chk("pre_rst_head", bus.tx_data, 32'd202);
    reset = 1'b1;
    m_reset();
    #1;
    chk("midrst_valid", {31'd0, bus.tx_valid}, 32'd0);
    drive(MMIO_TX_STATUS, 32'h0, 1'b0);
    #1;
    chk("midrst_status", bus.q_dmem, 32'h0002_0000);
    drive(32'd5, 32'h0, 1'b0);
    #1;
    chk("midrst_ram5", bus.q_dmem, 32'hDEAD_BEEF);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      bus.tx_ready = ((k / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: drive(32'($urandom_range(0, 15)), $urandom, 1'b1);
        2:    drive(32'($urandom_range(0, 15)), $urandom, 1'b0);
        3, 4: drive(MMIO_TX_DATA, $urandom, 1'b1);
        5:    drive(MMIO_TX_STATUS, $urandom, 1'b0);
        6:    drive(MMIO_TX_STATUS, $urandom, 1'(($urandom_range(0, 3) == 0)));
        7:    drive(MMIO_CYCLE, $urandom, 1'b0);
        8:    drive(MMIO_CYCLE, $urandom, 1'(($urandom_range(0, 3) == 0)));
        default: begin
          case ($urandom_range(0, 2))
            0:       a = 32'h0000_1000 | 32'($urandom_range(0, 15));
            1:       a = 32'hFFFF_FFF3;
            default: a = 32'h8000_0000 | 32'($urandom_range(0, 15));
          endcase
          drive(a, $urandom, 1'($urandom_range(0, 1)));
        end
      endcase
      #2;
      chk_all($sformatf("rnd%0d", k));
      tick();
    end

    // RAM sweep of everything the random phase touched
    for (int i = 0; i < 16; i++) begin
      drive(32'(i), 32'h0, 1'b0);
      #1;
      if (m_known(32'(i))) chk($sformatf("sweep%0d", i), bus.q_dmem, m_read(32'(i)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
